// File: rtl/apb2lb_tmo.sv
// APB slave to local-bus bridge (wen/wready writes, ren/rvalid reads); optional abort timer under `LB_TIMEOUT_EN.
// Latency: setup -> wen/ren next cycle; pready one cycle after the local-bus handshake (min one APB wait state).
// Backpressure: holds wen/ren (and so the APB access) until wready/rvalid, or until the timer aborts with pslverr.
module apb2lb_tmo #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int STRB_W      = DATA_W / 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic [STRB_W-1:0] pstrb,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic              wen,
   input  logic              wready,
   output logic [ADDR_W-1:0] raddr,
   output logic              ren,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rvalid
);

   if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("apb2lb_tmo: DATA_W must be 8, 16, 32 or 64");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
      $error("apb2lb_tmo: TIMEOUT_CYC must be in 1..65535");
   end

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dat;
      logic [STRB_W-1:0] strb;
   } wr_hdr_t;

   state_t              state_q, state_d;
   wr_hdr_t             wr_q, wr_d;
   logic [ADDR_W-1:0]   raddr_q, raddr_d;
   logic                wen_q, wen_d;
   logic                ren_q, ren_d;
   logic                pready_q, pready_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic                setup_vld;
   logic                tmo_hit;

   assign setup_vld = psel && !penable;

`ifdef LB_TIMEOUT_EN
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

   logic [15:0] cnt_q, cnt_d, cnt_nxt;
   logic        pslverr_q, pslverr_d;

   assign cnt_nxt = cnt_q + 16'd1;
   assign tmo_hit = (cnt_nxt == TMO_LIM);

   always_comb begin
      cnt_d     = cnt_q;
      pslverr_d = 1'b0;
      case (state_q)
         IDLE:  if (setup_vld) cnt_d = '0;
         WRITE: begin
            cnt_d     = cnt_nxt;
            pslverr_d = !wready && tmo_hit;
         end
         READ:  begin
            cnt_d     = cnt_nxt;
            pslverr_d = !rvalid && tmo_hit;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         pslverr_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign pslverr = pslverr_q;
`else
   assign tmo_hit = 1'b0;
   assign pslverr = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      raddr_d  = raddr_q;
      wen_d    = wen_q;
      ren_d    = ren_q;
      pready_d = 1'b0;
      prdata_d = '0;
      case (state_q)
         IDLE: begin
            if (setup_vld) begin
               if (pwrite) begin
                  wr_d    = '{addr: paddr, dat: pwdata, strb: pstrb};
                  wen_d   = 1'b1;
                  state_d = WRITE;
               end else begin
                  raddr_d = paddr;
                  ren_d   = 1'b1;
                  state_d = READ;
               end
            end
         end
         WRITE: begin
            // Handshake is checked before the timer so a late wready still wins.
            if (wready || tmo_hit) begin
               wen_d    = 1'b0;
               pready_d = 1'b1;
               state_d  = RESP;
            end
         end
         READ: begin
            if (rvalid) begin
               ren_d    = 1'b0;
               pready_d = 1'b1;
               prdata_d = rdata;
               state_d  = RESP;
            end else if (tmo_hit) begin
               ren_d    = 1'b0;
               pready_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         wr_q     <= '0;
         raddr_q  <= '0;
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         pready_q <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         raddr_q  <= raddr_d;
         wen_q    <= wen_d;
         ren_q    <= ren_d;
         pready_q <= pready_d;
         prdata_q <= prdata_d;
      end
   end

   assign waddr  = wr_q.addr;
   assign wdata  = wr_q.dat;
   assign wstrb  = wr_q.strb;
   assign wen    = wen_q;
   assign raddr  = raddr_q;
   assign ren    = ren_q;
   assign pready = pready_q;
   assign prdata = prdata_q;

endmodule

// File: doc/apb2lb_tmo.md
APB2LB_TMO -- requirements
Module: apb2lb_tmo

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width in bits on both buses.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width in bits; legal values are 8, 16, 32 and 64.
REQ-003 SHALL have parameter STRB_W, default DATA_W/8, meaning byte-strobe width; it SHALL never be overridden.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, meaning local-bus cycles before abort; legal range 1..65535.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have APB ports psel in 1, penable in 1, pwrite in 1, paddr in ADDR_W, pwdata in DATA_W, pstrb in STRB_W.
REQ-008 SHALL have APB ports prdata out DATA_W, pready out 1, pslverr out 1.
REQ-009 SHALL have local-bus write ports waddr out ADDR_W, wdata out DATA_W, wstrb out STRB_W, wen out 1, wready in 1.
REQ-010 SHALL have local-bus read ports raddr out ADDR_W, ren out 1, rdata in DATA_W, rvalid in 1.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-012 IDLE: psel=1 and penable=0 sampled -> latch paddr into waddr (write) or raddr (read); for a write also latch pwdata/pstrb; go to WRITE with wen=1 or READ with ren=1 on the next cycle.
REQ-013 WRITE: wen SHALL stay 1 until wen=1 and wready=1 are sampled on the same edge; then wen=0, pready=1, pslverr=0, state RESP.
REQ-014 READ: ren SHALL stay 1 until rvalid=1 is sampled; then prdata=rdata, ren=0, pready=1, pslverr=0, state RESP.
REQ-015 RESP: pready SHALL be 1 for exactly one cycle; then IDLE.
REQ-016 Minimum latency: with wready=1 or rvalid=1 in the first local-bus cycle, the APB access SHALL complete with exactly one wait state (pready high in the second ACCESS cycle).
REQ-017 waddr, wdata, wstrb, raddr SHALL hold their last latched value until the next setup phase of the same direction.
REQ-018 rvalid outside READ and wready outside WRITE SHALL be ignored.
REQ-019 pstrb SHALL be ignored on reads; pstrb=0 on writes SHALL still produce a wen pulse with wstrb=0.
REQ-020 wen and ren SHALL never be 1 simultaneously.
REQ-021 prdata SHALL be 0 except while pready=1 on a read response.
REQ-022 New setup phases SHALL be accepted only in IDLE.

Reset
REQ-023 rst=0 SHALL asynchronously force state IDLE, wen=0, ren=0, pready=0, pslverr=0, prdata=0, waddr=0, wdata=0, wstrb=0, raddr=0, timeout counter=0.
REQ-024 Reset asserted mid-transaction SHALL abort it with no pready pulse after release.

Configuration
REQ-025 Macro LB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to WRITE/READ, increment each cycle in those states, and on reaching TIMEOUT_CYC without handshake SHALL set wen/ren=0, pready=1, pslverr=1, prdata=0, state RESP.
REQ-026 Handshake on the same edge the counter reaches TIMEOUT_CYC SHALL win: normal response, pslverr=0.
REQ-027 Macro LB_TIMEOUT_EN undefined: no counter SHALL exist, pslverr SHALL be constant 0, and transactions SHALL wait indefinitely.

Verification
REQ-028 Write paddr=0x80000004, pwdata=0xdeadbeef, pstrb=0xF, wready=1 -> one wen pulse with waddr/wdata/wstrb matching, pready after one wait state, pslverr=0.
REQ-029 Write paddr=0x00C, pwdata=0xcafebabe, pstrb=0b0110 -> wstrb=0b0110; waddr still 0x00C one cycle after the handshake.
REQ-030 Write 0x010/0x0acce55 with wready=0 for 800 cycles, built without LB_TIMEOUT_EN -> wen held 800 cycles, completes with pslverr=0.
REQ-031 Read 0x014, rvalid with rdata=0xc0debabe 5 cycles after ren -> prdata=0xc0debabe at pready; ren=0 the cycle after rvalid.
REQ-032 With LB_TIMEOUT_EN, TIMEOUT_CYC=16, read 0x008 with rvalid never asserted -> ren drops after 16 cycles, pready=1, pslverr=1, prdata=0; next write completes normally.
REQ-033 rst=0 asserted 3 cycles into a pending read -> ren=0 immediately, no pready after release, next transfer completes normally.
